// File: rtl/mem_resp_pkg.sv
// Shared encodings for the instruction/data memory responder: request ops,
// FSM states and the one-hot fetch lane strobes.
package mem_resp_pkg;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_FETCH   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic [3:0] IRW_LANE0 = 4'b0001;
  localparam logic [3:0] IRW_LANE1 = 4'b0010;
  localparam logic [3:0] IRW_LANE2 = 4'b0100;
  localparam logic [3:0] IRW_LANE3 = 4'b1000;

  // Map a fetch byte index to the irwrite lane that assembles it into instr.
  function automatic logic [3:0] lane_strobe(input logic [1:0] k);
    logic [3:0] s;
    case (k)
      2'd0:    s = IRW_LANE0;
      2'd1:    s = IRW_LANE1;
      2'd2:    s = IRW_LANE2;
      default: s = IRW_LANE3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide RAM: synchronous write, asynchronous read, contents never reset.
module byte_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Single write port; the caller has already chosen between init and request writes.
  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdata;
  end

  assign rdata = mem[radr];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the 8-bit multicycle datapath. Serves byte
// reads, byte writes and 4-byte instruction fetches with a fixed number of
// wait states before every byte transfer. All response outputs are registered.
//
// Handshake: a request is taken on a rising clock edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE with no preload
// write in progress, and req_valid while busy is simply ignored (no queue).
module instr_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_wdata,
  output logic [DW-1:0] memdata,
  output logic [3:0]    irwrite,
  output logic          rdata_valid,
  output logic          done,
  output logic          err,
  input  logic          init_we,
  input  logic [AW-1:0] init_adr,
  input  logic [DW-1:0] init_data,
  output logic [1:0]    state_dbg
);

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WS_LAST  = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    k_q, k_d;
  logic [1:0]    op_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q;
  logic          accept;
  logic          last_xfer;

  logic          ram_we;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;

  assign req_ready = (state_q == ST_IDLE) && !init_we;
  assign accept    = req_valid && req_ready;
  assign state_dbg = state_q;

  // Fetch bytes walk from the base address; the AW-bit add wraps naturally.
  assign ram_radr  = adr_q + AW'(k_q);

  // Preload writes only land in IDLE and request writes only in XFER, so the
  // two sources never collide.
  assign ram_we    = ((state_q == ST_IDLE) && init_we) ||
                     ((state_q == ST_XFER) && (op_q == OP_WRITE));
  assign ram_wadr  = (state_q == ST_IDLE) ? init_adr  : adr_q;
  assign ram_wdata = (state_q == ST_IDLE) ? init_data : wdata_q;

  byte_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wadr  (ram_wadr),
    .wdata (ram_wdata),
    .radr  (ram_radr),
    .rdata (ram_rdata)
  );

  // State, wait counter and byte index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: optional wait phase before each byte, one XFER cycle per byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    last_xfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          k_d     = '0;
          cnt_d   = '0;
          state_d = HAS_WAIT ? ST_WAIT : ST_XFER;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WS_LAST) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_XFER: begin
        last_xfer = (op_q != OP_FETCH) || (k_q == 2'd3);
        if (last_xfer) begin
          state_d = ST_IDLE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = HAS_WAIT ? ST_WAIT : ST_XFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields captured at accept and held for the whole transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_READ;
      adr_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      adr_q   <= req_adr;
      wdata_q <= req_wdata;
    end
  end

  // Registered response: strobes pulse for one cycle, memdata holds between transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memdata     <= '0;
      irwrite     <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      irwrite     <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (state_q == ST_XFER) begin
        done <= last_xfer;
        case (op_q)
          OP_READ: begin
            memdata     <= ram_rdata;
            rdata_valid <= 1'b1;
          end
          OP_FETCH: begin
            memdata <= ram_rdata;
            irwrite <= lane_strobe(k_q);
          end
          OP_ILLEGAL: err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (0 and 2 wait states) share
// one stimulus stream; each has its own expected queue and monitor.
module tb_instr_mem_responder;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_op;
  logic [7:0] req_adr;
  logic [7:0] req_wdata;
  logic       init_we;
  logic [7:0] init_adr;
  logic [7:0] init_data;

  logic       ready0, rdv0, done0, err0;
  logic [7:0] md0;
  logic [3:0] irw0;
  logic [1:0] st0;
  logic       ready2, rdv2, done2, err2;
  logic [7:0] md2;
  logic [3:0] irw2;
  logic [1:0] st2;

  instr_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
    .req_op(req_op), .req_adr(req_adr), .req_wdata(req_wdata),
    .memdata(md0), .irwrite(irw0), .rdata_valid(rdv0), .done(done0), .err(err0),
    .init_we(init_we), .init_adr(init_adr), .init_data(init_data), .state_dbg(st0)
  );

  instr_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
    .req_op(req_op), .req_adr(req_adr), .req_wdata(req_wdata),
    .memdata(md2), .irwrite(irw2), .rdata_valid(rdv2), .done(done2), .err(err2),
    .init_we(init_we), .init_adr(init_adr), .init_data(init_data), .state_dbg(st2)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  // Entry layout: {latency[7:0], err, done, rdata_valid, irwrite[3:0], memdata[7:0]}
  logic [22:0] exp_q0[$];
  logic [22:0] exp_q2[$];
  int          total = 0;
  int          bad   = 0;
  int          acc0  = 0;
  int          acc2  = 0;
  logic [7:0]  last_md = 8'h00;

  function automatic logic [22:0] pack(input logic [7:0] lat, input logic e, input logic d,
                                       input logic rv, input logic [3:0] irw, input logic [7:0] md);
    return {lat, e, d, rv, irw, md};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Latency unit is (1 + wait states): 1 cycle for u0, 3 cycles for u2.
  task automatic push_ev(input int mult, input logic e, input logic d, input logic rv,
                         input logic [3:0] irw, input logic [7:0] md);
    exp_q0.push_back(pack(8'(mult * 1), e, d, rv, irw, md));
    exp_q2.push_back(pack(8'(mult * 3), e, d, rv, irw, md));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [22:0] e, a;
    if (reset === 1'b1 && (irw0 != 4'b0 || rdv0 || done0 || err0)) begin
      a = pack(8'(cyc - acc0), err0, done0, rdv0, irw0, md0);
      total++;
      if (exp_q0.size() == 0) begin
        bad++;
        $display("FAIL u0_unexpected: got %h expected none", a);
      end else begin
        e = exp_q0.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL u0_resp: got %h expected %h (lat,err,done,rv,irw,md)", a, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [22:0] e, a;
    if (reset === 1'b1 && (irw2 != 4'b0 || rdv2 || done2 || err2)) begin
      a = pack(8'(cyc - acc2), err2, done2, rdv2, irw2, md2);
      total++;
      if (exp_q2.size() == 0) begin
        bad++;
        $display("FAIL u2_unexpected: got %h expected none", a);
      end else begin
        e = exp_q2.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL u2_resp: got %h expected %h (lat,err,done,rv,irw,md)", a, e);
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic wait_idle();
    int n = 0;
    while (!(ready0 && ready2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'(ready0 & ready2), 32'd1);
  endtask

  task automatic preload(input logic [7:0] adr, input logic [7:0] d);
    wait_idle();
    init_we   = 1'b1;
    init_adr  = adr;
    init_data = d;
    @(posedge clk); #1;
    init_we   = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] adr, input logic [7:0] wd);
    wait_idle();
    req_valid = 1'b1;
    req_op    = op;
    req_adr   = adr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc0 = cyc;
    acc2 = cyc;
  endtask

  task automatic do_read(input logic [7:0] adr, input logic [7:0] exp);
    issue(2'b00, adr, 8'h00);
    push_ev(1, 1'b0, 1'b1, 1'b1, 4'b0000, exp);
    last_md = exp;
  endtask

  task automatic do_write(input logic [7:0] adr, input logic [7:0] d);
    issue(2'b01, adr, d);
    push_ev(1, 1'b0, 1'b1, 1'b0, 4'b0000, last_md);
  endtask

  // exp holds the instruction word: byte k is the one read from adr+k.
  task automatic do_fetch(input logic [7:0] adr, input logic [31:0] exp);
    issue(2'b10, adr, 8'h00);
    for (int k = 0; k < 4; k++)
      push_ev(k + 1, 1'b0, (k == 3), 1'b0, 4'(1 << k), exp[8*k +: 8]);
    last_md = exp[31:24];
  endtask

  task automatic do_illegal(input logic [7:0] adr);
    issue(2'b11, adr, 8'h00);
    push_ev(1, 1'b1, 1'b1, 1'b0, 4'b0000, last_md);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_adr   = 8'h00;
    req_wdata = 8'h00;
    init_we   = 1'b0;
    init_adr  = 8'h00;
    init_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_md0", 32'(md0), 32'h0);
    check("rst_irw0", 32'(irw0), 32'h0);
    check("rst_flags0", 32'({rdv0, done0, err0}), 32'h0);
    check("rst_md2", 32'(md2), 32'h0);
    check("rst_irw2", 32'(irw2), 32'h0);
    check("rst_state", 32'({st0, st2}), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'({ready0, ready2}), 32'h3);

    // Basic fetch; u2 checks the 2-wait-state spacing and done 12 cycles after accept
    preload(8'h00, 8'h20);
    preload(8'h01, 8'h20);
    preload(8'h02, 8'h85);
    preload(8'h03, 8'h00);
    do_fetch(8'h00, 32'h00852020);

    // Write then read back
    do_write(8'h10, 8'hA5);
    do_read(8'h10, 8'hA5);

    // Fetch wrapping around the top of the address space
    preload(8'hFE, 8'h11);
    preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);
    preload(8'h01, 8'h44);
    do_fetch(8'hFE, 32'h44332211);

    // Reset during the 2nd byte of a fetch: u0 has shown byte 0 only, u2 nothing yet
    issue(2'b10, 8'hFE, 8'h00);
    exp_q0.push_back(pack(8'd1, 1'b0, 1'b0, 1'b0, 4'b0001, 8'h11));
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_irw", 32'({irw0, irw2}), 32'h0);
    check("abort_md", 32'({md0, md2}), 32'h0);
    check("abort_flags", 32'({rdv0, done0, err0, rdv2, done2, err2}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b1;
    last_md = 8'h00;
    @(posedge clk); #1;
    check("abort_ready", 32'({ready0, ready2}), 32'h3);
    check("abort_state", 32'({st0, st2}), 32'h0);
    check("abort_drained", 32'(exp_q0.size() + exp_q2.size()), 32'd0);
    do_fetch(8'hFE, 32'h44332211);
    do_fetch(8'h00, 32'h00854433);

    // Illegal op leaves RAM and memdata alone
    do_illegal(8'h10);
    do_read(8'h10, 8'hA5);

    // Preload together with a request: the request is not taken that cycle
    wait_idle();
    init_we   = 1'b1;
    init_adr  = 8'h20;
    init_data = 8'h5A;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_adr   = 8'h10;
    #1;
    check("init_blocks_ready", 32'({ready0, ready2}), 32'h0);
    @(posedge clk); #1;
    init_we   = 1'b0;
    req_valid = 1'b0;
    check("init_no_accept", 32'({st0, st2}), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    do_read(8'h20, 8'h5A);

    // Drain
    n = 0;
    while ((exp_q0.size() != 0 || exp_q2.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q2_empty", 32'(exp_q2.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
